mem_access_ctrl: RTL and testbench

Debug-side sequencer that owns the instruction and data memories while the CPU is halted. It accepts block commands of the form "read N words from IM/DM" or "write N words to IM/DM" from the serial debug unit. It walks the address range and pulses the memory write enables. Read words stream back through a valid/ready handshake, and write words are pulled in through the same kind of handshake.

---
 rtl/dbg_pkg.sv | 29 ++
 rtl/mem_access_ctrl_if.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug memory-access sequencer.
//   DEF_ADDR_W / DEF_DATA_W : default memory word-address and data widths
//   op_e                    : block command opcodes
//   state_e                 : sequencer states
package dbg_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_RD_DM = 2'd0,
        OP_RD_IM = 2'd1,
        OP_WR_DM = 2'd2,
        OP_WR_IM = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_OUT,
        ST_WR_WAIT,
        ST_WR_PULSE,
        ST_DONE
    } state_e;

    // Bit 1 of the opcode selects write, bit 0 selects IM.
    function automatic logic op_is_write(input op_e op);
        return op[1];
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Host-side streams of the debug memory-access sequencer.
//   cmd_* : block command (op, base word address, word count)
//   wr_*  : write-word stream into the sequencer
//   rd_*  : read-word stream out of the sequencer, tagged with its address
// master = debug unit side, slave = sequencer side.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = dbg_pkg::DEF_ADDR_W,
    parameter int DATA_W = dbg_pkg::DEF_DATA_W
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data, rd_addr,
        output rd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data, rd_addr,
        input  rd_ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Debug-side sequencer owning IM/DM while the CPU is halted. Executes block
// read/write commands, walking the word address range (wrapping at the top).
//   clk, rstn        : clock, asynchronous active-low reset
//   debug            : CPU halted; commands accepted only while high, a fall
//                      while busy aborts the command (done still pulses)
//   bus              : command / write-stream / read-stream (slave side);
//                      its ADDR_W/DATA_W must match this module's
//   addr, din        : shared memory address and write data (registered)
//   we_dm, we_im     : one-cycle write strobes
//   dout_dm, dout_im : asynchronous memory read data
//   busy, done       : command in progress / end-of-command pulse
module mem_access_ctrl #(
    parameter int ADDR_W = dbg_pkg::DEF_ADDR_W,
    parameter int DATA_W = dbg_pkg::DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               debug,
    mem_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  din,
    output logic               we_dm,
    output logic               we_im,
    input  logic [DATA_W-1:0]  dout_dm,
    input  logic [DATA_W-1:0]  dout_im,
    output logic               busy,
    output logic               done
);
    import dbg_pkg::*;

    state_e            state, state_nx;
    op_e               op;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   remaining;
    logic              armed;     // cmd_ready held low until the first edge after reset
    logic              rd_prime;  // first read word waits one cycle for addr to load
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic cmd_fire, rd_fire, wr_fire, last;

    function automatic logic [DATA_W-1:0] rd_mux(input op_e o,
                                                 input logic [DATA_W-1:0] dm,
                                                 input logic [DATA_W-1:0] im);
        return (o == OP_RD_IM) ? im : dm;
    endfunction

    // Strobes and stream handshakes are gated by debug so an abort takes
    // effect in the same cycle debug falls.
    assign bus.cmd_ready = armed & debug & (state == ST_IDLE);
    assign bus.rd_valid  = debug & (state == ST_RD_OUT);
    assign bus.wr_ready  = debug & (state == ST_WR_WAIT);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_addr   = rd_addr_q;

    assign we_dm = debug & (state == ST_WR_PULSE) & (op == OP_WR_DM);
    assign we_im = debug & (state == ST_WR_PULSE) & (op == OP_WR_IM);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign rd_fire  = bus.rd_valid & bus.rd_ready;
    assign wr_fire  = bus.wr_valid & bus.wr_ready;
    assign last     = (remaining == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (bus.cmd_len == '0)                 state_nx = ST_DONE;
                    else if (op_is_write(op_e'(bus.cmd_op))) state_nx = ST_WR_WAIT;
                    else                                   state_nx = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (!debug)        state_nx = ST_DONE;
                else if (!rd_prime) state_nx = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (!debug)       state_nx = ST_DONE;
                else if (rd_fire) state_nx = last ? ST_DONE : ST_RD_ADDR;
            end
            ST_WR_WAIT: begin
                if (!debug)       state_nx = ST_DONE;
                else if (wr_fire) state_nx = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (!debug) state_nx = ST_DONE;
                else        state_nx = last ? ST_DONE : ST_WR_WAIT;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed     <= 1'b0;
            op        <= OP_RD_DM;
            cur       <= '0;
            remaining <= '0;
            rd_prime  <= 1'b0;
            addr      <= '0;
            din       <= '0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op        <= op_e'(bus.cmd_op);
                        cur       <= bus.cmd_base;
                        remaining <= bus.cmd_len;
                        rd_prime  <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    addr     <= cur;
                    rd_prime <= 1'b0;
                    // addr already equals cur here, so dout is for this word
                    if (!rd_prime && debug) begin
                        rd_data_q <= rd_mux(op, dout_dm, dout_im);
                        rd_addr_q <= cur;
                    end
                end
                ST_RD_OUT: begin
                    if (rd_fire) begin
                        cur       <= cur + 1'b1;
                        addr      <= cur + 1'b1;  // preload keeps 2 cycles/word
                        remaining <= remaining - 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    addr <= cur;
                    if (wr_fire) din <= bus.wr_data;
                end
                ST_WR_PULSE: begin
                    if (debug) begin
                        cur       <= cur + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: behavioural IM/DM, event counters and
// immediate-assertion checks along a linear sequence of commands.
module tb_mem_access_ctrl;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        debug;
    logic [9:0]  addr;
    logic [31:0] din, dout_dm, dout_im;
    logic        we_dm, we_im, busy, done;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk     (clk),
        .rstn    (rstn),
        .debug   (debug),
        .bus     (bus),
        .addr    (addr),
        .din     (din),
        .we_dm   (we_dm),
        .we_im   (we_im),
        .dout_dm (dout_dm),
        .dout_im (dout_im),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural memories: DM[i] = i, IM[i] = 0xC0000000 + i at start.
    logic [31:0] dm_mem [0:1023];
    logic [31:0] im_mem [0:1023];
    bit          loaded = 1'b0;
    assign dout_dm = dm_mem[addr];
    assign dout_im = im_mem[addr];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) begin
                dm_mem[i] <= 32'(i);
                im_mem[i] <= 32'hC000_0000 + 32'(i);
            end
            loaded <= 1'b1;
        end else begin
            if (we_dm) dm_mem[addr] <= din;
            if (we_im) im_mem[addr] <= din;
        end
    end

    // Event monitor (samples pre-edge values at each rising edge).
    int          n_we_dm = 0, n_we_im = 0, n_done = 0, n_rd = 0, n_both = 0;
    logic [9:0]  rd_log_addr [0:63];
    logic [31:0] rd_log_data [0:63];

    always @(posedge clk) begin
        if (we_dm) n_we_dm <= n_we_dm + 1;
        if (we_im) n_we_im <= n_we_im + 1;
        if (we_dm && we_im) n_both <= n_both + 1;
        if (done) n_done <= n_done + 1;
        if (bus.rd_valid && bus.rd_ready) begin
            rd_log_addr[n_rd[5:0]] <= bus.rd_addr;
            rd_log_data[n_rd[5:0]] <= bus.rd_data;
            n_rd <= n_rd + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a command from a negedge; returns at the negedge after accept.
    task automatic send_cmd(input logic [1:0] op, input logic [9:0] base, input logic [10:0] len);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("cmd_accept", 64'(ok), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Push one write word after gap idle cycles; returns in the strobe cycle.
    task automatic push_word(input logic [31:0] d, input int gap, input bit im, input logic [9:0] a);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (bus.wr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wr_accept", 64'(ok), 64'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("strobe_we_im", 64'(we_im), 64'(im));
        chk("strobe_we_dm", 64'(we_dm), 64'(!im));
        chk("strobe_addr", 64'(addr), 64'(a));
        chk("strobe_din", 64'(din), 64'(d));
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("done_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, wd0, wi0;
        rstn = 1'b0;
        debug = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0;  bus.wr_data = '0;  bus.rd_ready = 1'b0;

        // Reset state
        step(2);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("rst_we", 64'({we_dm, we_im}), 64'd0);
        chk("rst_addr_din", 64'({addr, din}), 64'd0);
        chk("rst_rd_bus", 64'({bus.rd_addr, bus.rd_data}), 64'd0);
        rstn = 1'b1;
        #1 chk("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
        step(1);
        chk("cmd_ready_after_edge", 64'(bus.cmd_ready), 64'd1);

        // Read DM across the top of the address space
        bus.rd_ready = 1'b1;
        r0 = n_rd; d0 = n_done;
        send_cmd(OP_RD_DM, 10'h3FE, 11'd4);
        chk("rd_lat_e0", 64'(bus.rd_valid), 64'd0);
        chk("rd_busy", 64'(busy), 64'd1);
        step(1);
        chk("rd_lat_e1", 64'(bus.rd_valid), 64'd0);
        step(1);
        chk("rd_lat_e2", 64'(bus.rd_valid), 64'd1);
        chk("rd_first_addr", 64'(bus.rd_addr), 64'h3FE);
        wait_done(40);
        chk("rd_beats", 64'(n_rd - r0), 64'd4);
        chk("rd_addr0", 64'(rd_log_addr[(r0+0)%64]), 64'h3FE);
        chk("rd_addr1", 64'(rd_log_addr[(r0+1)%64]), 64'h3FF);
        chk("rd_addr2", 64'(rd_log_addr[(r0+2)%64]), 64'h000);
        chk("rd_addr3", 64'(rd_log_addr[(r0+3)%64]), 64'h001);
        chk("rd_data0", 64'(rd_log_data[(r0+0)%64]), 64'h3FE);
        chk("rd_data2", 64'(rd_log_data[(r0+2)%64]), 64'h000);
        chk("rd_data3", 64'(rd_log_data[(r0+3)%64]), 64'h001);
        step(1);
        chk("rd_busy_after_done", 64'(busy), 64'd0);
        chk("rd_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
        step(1);
        chk("rd_done_once", 64'(n_done - d0), 64'd1);
        bus.rd_ready = 1'b0;

        // Write IM with wr_valid gaps
        wd0 = n_we_dm; wi0 = n_we_im;
        send_cmd(OP_WR_IM, 10'h010, 11'd3);
        push_word(32'hA, 0, 1'b1, 10'h010);
        push_word(32'hB, 5, 1'b1, 10'h011);
        push_word(32'hC, 0, 1'b1, 10'h012);
        wait_done(20);
        step(1);
        chk("wr_im_pulses", 64'(n_we_im - wi0), 64'd3);
        chk("wr_im_no_dm", 64'(n_we_dm - wd0), 64'd0);
        chk("wr_im_mem10", 64'(im_mem[10'h010]), 64'hA);
        chk("wr_im_mem12", 64'(im_mem[10'h012]), 64'hC);

        // Read IM with back-pressure on the first word
        r0 = n_rd;
        send_cmd(OP_RD_IM, 10'h020, 11'd2);
        step(2);
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 64'(bus.rd_valid), 64'd1);
            chk("bp_data", 64'(bus.rd_data), 64'hC000_0020);
            chk("bp_addr", 64'(bus.rd_addr), 64'h020);
            step(1);
        end
        bus.rd_ready = 1'b1;
        wait_done(20);
        chk("bp_beats", 64'(n_rd - r0), 64'd2);
        chk("bp_addr1", 64'(rd_log_addr[(r0+1)%64]), 64'h021);
        chk("bp_data1", 64'(rd_log_data[(r0+1)%64]), 64'hC000_0021);
        step(1);
        bus.rd_ready = 1'b0;

        // Zero-length command
        r0 = n_rd; wd0 = n_we_dm; wi0 = n_we_im;
        bus.rd_ready = 1'b1;
        send_cmd(OP_WR_DM, 10'h005, 11'd0);
        chk("len0_done", 64'(done), 64'd1);
        step(1);
        chk("len0_done_low", 64'(done), 64'd0);
        chk("len0_busy_low", 64'(busy), 64'd0);
        chk("len0_no_we", 64'((n_we_dm - wd0) + (n_we_im - wi0)), 64'd0);
        chk("len0_no_rd", 64'(n_rd - r0), 64'd0);
        bus.rd_ready = 1'b0;

        // Write DM, debug dropped after the third strobe
        wd0 = n_we_dm; d0 = n_done;
        send_cmd(OP_WR_DM, 10'h100, 11'd8);
        push_word(32'h11, 0, 1'b0, 10'h100);
        push_word(32'h22, 0, 1'b0, 10'h101);
        push_word(32'h33, 0, 1'b0, 10'h102);
        step(1);
        debug = 1'b0;
        #1 chk("abort_wr_ready", 64'(bus.wr_ready), 64'd0);
        step(1);
        chk("abort_done", 64'(done), 64'd1);
        step(1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cmd_ready0", 64'(bus.cmd_ready), 64'd0);
        step(2);
        chk("abort_cmd_ready_hold", 64'(bus.cmd_ready), 64'd0);
        chk("abort_pulses", 64'(n_we_dm - wd0), 64'd3);
        chk("abort_done_cnt", 64'(n_done - d0), 64'd1);
        chk("abort_mem102", 64'(dm_mem[10'h102]), 64'h33);
        chk("abort_mem103", 64'(dm_mem[10'h103]), 64'h103);
        debug = 1'b1;
        #1 chk("abort_cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
        step(1);

        // Reset in the middle of a write strobe
        send_cmd(OP_WR_DM, 10'h200, 11'd2);
        push_word(32'h1234, 0, 1'b0, 10'h200);
        wd0 = n_we_dm; d0 = n_done;
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_we", 64'({we_dm, we_im}), 64'd0);
        chk("mid_rst_busy_done", 64'({busy, done}), 64'd0);
        chk("mid_rst_addr_din", 64'({addr, din}), 64'd0);
        chk("mid_rst_ready", 64'({bus.cmd_ready, bus.wr_ready, bus.rd_valid}), 64'd0);
        step(2);
        chk("mid_rst_no_done", 64'(n_done - d0), 64'd0);
        chk("mid_rst_no_write", 64'(n_we_dm - wd0), 64'd0);
        chk("mid_rst_mem", 64'(dm_mem[10'h200]), 64'h200);
        rstn = 1'b1;
        #1 chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        step(1);
        wd0 = n_we_dm;
        send_cmd(OP_WR_DM, 10'h200, 11'd1);
        push_word(32'h55, 0, 1'b0, 10'h200);
        wait_done(20);
        step(1);
        chk("post_rst_write", 64'(dm_mem[10'h200]), 64'h55);
        chk("post_rst_pulses", 64'(n_we_dm - wd0), 64'd1);
        chk("we_exclusive", 64'(n_both), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
